systolic_result_drain: RTL and testbench
========================================

Name: systolic_result_drain

Overview:
- Output-side counterpart of the buffered systolic array.
- Snapshots the flat result bus when the array's calc_done_flag rises, then streams the result matrix out one row per beat over a valid/ready handshake.
- Sits between the systolic array and the downstream writeback/accumulation logic, so the array can start its next tile while the previous results drain.

Parameters:
- WIDTH, 16, bits per result element.
- ARR_HEIGHT, 4, rows in the result matrix; this is the number of beats per drain.
- ARR_WIDTH, 4, columns in the result matrix; this is the number of elements per beat.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- calc_done_flag  input  1  level from the array; a rising edge means in_c is final.
- in_c  input  ARR_HEIGHT*ARR_WIDTH*WIDTH  result bus; element (r,c) is at bit offset (r*ARR_WIDTH+c)*WIDTH.
- out_row  output  ARR_WIDTH*WIDTH  current row; column c is at offset c*WIDTH.
- out_row_idx  output  max(1,$clog2(ARR_HEIGHT))  index of the row on out_row.
- out_valid  output  1  out_row holds a valid row.
- out_ready  input  1  downstream accepts the beat.
- out_last  output  1  high with out_valid on row ARR_HEIGHT-1.
- busy  output  1  a drain is in progress (state DRAIN).
- overrun  output  1  sticky; a new result arrived while draining.

Behaviour:
- Reset (reset=0, async) values:
  - state=IDLE; out_valid=0, out_last=0, busy=0, overrun=0.
  - out_row_idx=0, snapshot=0, done_q=0.
- Edge detect:
  - done_q registers calc_done_flag every cycle.
  - rise = calc_done_flag & ~done_q.
  - A level held high gives exactly one rise.
  - calc_done_flag already high when reset deasserts counts as a rise on the first clock.
- Handshake: a beat transfers on any cycle with out_valid & out_ready.
- FSM, IDLE:
  - out_valid=0.
  - On rise: capture all of in_c into the snapshot, set row_idx=0 and move to DRAIN.
  - Latency is 1: out_valid is high in the cycle after the sampled rise.
- FSM, DRAIN:
  - out_valid=1 and busy=1.
  - out_row = snapshot row row_idx; out_row_idx = row_idx.
  - out_last = (row_idx==ARR_HEIGHT-1).
  - On a transfer with row_idx<ARR_HEIGHT-1: row_idx increments.
  - On a transfer with row_idx==ARR_HEIGHT-1: return to IDLE.
- Output stability: while out_valid & ~out_ready, out_row, out_row_idx and out_last hold stable (no drops, no skips).
- Throughput: with out_ready held high, a drain takes exactly ARR_HEIGHT consecutive cycles.
- Rise during DRAIN, except on the final transfer:
  - Set overrun=1; it holds until reset.
  - The snapshot, row_idx and the in-progress drain are unaffected.
  - The new result is dropped.
- Rise in the same cycle as the final transfer (row ARR_HEIGHT-1 accepted):
  - Treat as a back-to-back capture; overrun is not set.
  - Load the new snapshot, set row_idx=0 and stay in DRAIN.
  - out_valid stays high with no bubble.
- ARR_HEIGHT=1: every beat has out_last=1 and out_row_idx=0.
- Reset asserted mid-drain: drain is abandoned immediately, all outputs return to reset values, no partial beat is replayed.
- Arithmetic: none on data; values pass through bit-exact. Format (float or int) is irrelevant to this block.
- Storage: one snapshot register of ARR_HEIGHT*ARR_WIDTH*WIDTH bits. The row select is a mux on registered row_idx, so no combinational path runs from in_c to outputs.

Test Plan (WIDTH=16, ARR_HEIGHT=ARR_WIDTH=4; element(r,c)=16'h0100*r+c, e.g. row 2 = {16'h0203,16'h0202,16'h0201,16'h0200}):
- Basic drain:
  - Stimulus: release reset, hold out_ready=1, raise calc_done_flag and hold it.
  - Required: out_valid rises 1 cycle after the sampled edge; 4 consecutive beats with idx 0,1,2,3; out_last only on idx 3; then out_valid=0 and busy=0; no second drain while the flag stays high.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1,0,1,1.
  - Required: 4 beats total, each row accepted exactly once in order; out_row stable during stalls.
- Overrun:
  - Stimulus: during the row-1 stall, drop calc_done_flag, change in_c to all 16'hFFFF, raise the flag again.
  - Required: overrun=1 and stays 1; remaining rows are the original values 0x01xx–0x03xx; no 0xFFFF beat appears.
- Back-to-back:
  - Stimulus: rise calc_done_flag in the exact cycle row 3 is accepted, with in_c = element+16'h1000.
  - Required: out_valid never drops; the next beat is idx 0 = {16'h1003,16'h1002,16'h1001,16'h1000}; overrun stays 0.
- Async reset mid-drain:
  - Stimulus: pull reset=0 between clock edges after the row-1 transfer.
  - Required: out_valid, busy, overrun and out_row_idx go to 0 immediately, without waiting for a clock edge; after release with the flag low, no beats are produced.

Source files
------------

// File: rtl/systolic_result_drain.sv
// systolic_result_drain
// Captures the systolic array's flat result bus when calc_done_flag rises and
// streams the captured matrix out one row per beat over a valid/ready handshake,
// so the array can begin its next tile while the previous results drain.
//
// Ports:
//   clk            - single clock, rising-edge active
//   reset          - asynchronous, active-low reset
//   calc_done_flag - level from the array; a rising edge marks in_c as final
//   in_c           - result bus, element (r,c) at bit offset (r*ARR_WIDTH+c)*WIDTH
//   out_row        - current row, column c at bit offset c*WIDTH
//   out_row_idx    - index of the row presented on out_row
//   out_valid      - out_row holds a valid row
//   out_ready      - downstream accepts the beat
//   out_last       - asserted with out_valid on the final row
//   busy           - a drain is in progress
//   overrun        - sticky; a new result arrived mid-drain and was dropped
module systolic_result_drain #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ARR_HEIGHT = 4,
    parameter int unsigned ARR_WIDTH  = 4
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       calc_done_flag,
    input  logic [ARR_HEIGHT*ARR_WIDTH*WIDTH-1:0]      in_c,
    output logic [ARR_WIDTH*WIDTH-1:0]                 out_row,
    output logic [((ARR_HEIGHT > 1) ? $clog2(ARR_HEIGHT) : 1)-1:0] out_row_idx,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic                                       out_last,
    output logic                                       busy,
    output logic                                       overrun
);

    localparam int unsigned ROW_W    = ARR_WIDTH * WIDTH;
    localparam int unsigned SNAP_W   = ARR_HEIGHT * ROW_W;
    localparam int unsigned IDX_W    = (ARR_HEIGHT > 1) ? $clog2(ARR_HEIGHT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARR_HEIGHT - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t               state_q,     state_d;
    logic [SNAP_W-1:0]    snap_q,      snap_d;
    logic [IDX_W-1:0]     row_idx_q,   row_idx_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q,  out_last_d;
    logic                 busy_q,      busy_d;
    logic                 overrun_q,   overrun_d;
    logic                 done_q,      done_d;

    logic rise;
    logic xfer;
    logic final_xfer;

    assign rise       = calc_done_flag & ~done_q;
    assign xfer       = out_valid_q & out_ready;
    assign final_xfer = xfer & (row_idx_q == LAST_IDX);

    // Next-state, snapshot capture and registered-output computation
    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        row_idx_d = row_idx_q;
        overrun_d = overrun_q;
        done_d    = calc_done_flag;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d   = DRAIN;
                    snap_d    = in_c;
                    row_idx_d = '0;
                end
            end
            DRAIN: begin
                if (final_xfer) begin
                    // A rise coinciding with the last accepted row chains
                    // straight into the next drain without a bubble.
                    if (rise) begin
                        snap_d    = in_c;
                        row_idx_d = '0;
                    end else begin
                        state_d   = IDLE;
                        row_idx_d = '0;
                    end
                end else begin
                    if (xfer) begin
                        row_idx_d = row_idx_q + IDX_W'(1);
                    end
                    // New result while the snapshot is still in use is dropped
                    if (rise) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                row_idx_d = '0;
            end
        endcase

        out_valid_d = (state_d == DRAIN);
        busy_d      = (state_d == DRAIN);
        out_last_d  = (state_d == DRAIN) && (row_idx_d == LAST_IDX);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            row_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            row_idx_q   <= row_idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            done_q      <= done_d;
        end
    end

    // Row select from the registered snapshot by the registered row index
    always_comb begin
        out_row = '0;
        for (int r = 0; r < int'(ARR_HEIGHT); r++) begin
            if (row_idx_q == IDX_W'(r)) begin
                out_row = snap_q[r*ROW_W +: ROW_W];
            end
        end
    end

    assign out_row_idx = row_idx_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: expected rows are queued when a
// capture is provoked and compared as beats are accepted.
module tb_systolic_result_drain;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned H     = 4;
    localparam int unsigned W     = 4;

    typedef struct packed {
        logic [W*WIDTH-1:0] row;
        logic [1:0]         idx;
        logic               last;
    } beat_t;

    logic                   clk;
    logic                   reset;
    logic                   calc_done_flag;
    logic [H*W*WIDTH-1:0]   in_c;
    logic [W*WIDTH-1:0]     out_row;
    logic [1:0]             out_row_idx;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_last;
    logic                   busy;
    logic                   overrun;

    int tests = 0;
    int fails = 0;

    beat_t sb[$];
    logic               stall_prev = 1'b0;
    logic [W*WIDTH-1:0] held_row;
    logic [1:0]         held_idx;
    logic               held_last;

    systolic_result_drain #(
        .WIDTH     (WIDTH),
        .ARR_HEIGHT(H),
        .ARR_WIDTH (W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .calc_done_flag(calc_done_flag),
        .in_c          (in_c),
        .out_row       (out_row),
        .out_row_idx   (out_row_idx),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .busy          (busy),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [H*W*WIDTH-1:0] mk_in(input logic [15:0] add);
        logic [H*W*WIDTH-1:0] v;
        v = '0;
        for (int r = 0; r < int'(H); r++)
            for (int c = 0; c < int'(W); c++)
                v[(r*W+c)*WIDTH +: WIDTH] = add + 16'(r*256 + c);
        return v;
    endfunction

    function automatic logic [W*WIDTH-1:0] mk_row(input logic [15:0] add, input int r);
        logic [W*WIDTH-1:0] v;
        v = '0;
        for (int c = 0; c < int'(W); c++)
            v[c*WIDTH +: WIDTH] = add + 16'(r*256 + c);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_rows(input logic [15:0] add);
        beat_t b;
        for (int r = 0; r < int'(H); r++) begin
            b.row  = mk_row(add, r);
            b.idx  = 2'(r);
            b.last = (r == int'(H) - 1);
            sb.push_back(b);
        end
    endtask

    // Checks the beat about to transfer and output stability across stalls
    task automatic mon();
        beat_t e;
        if (stall_prev && out_valid) begin
            chk("stall_row",  64'(out_row),     64'(held_row));
            chk("stall_idx",  64'(out_row_idx), 64'(held_idx));
            chk("stall_last", 64'(out_last),    64'(held_last));
        end
        if (out_valid && out_ready) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL extra_beat observed=idx %0d row %0h expected=no beat",
                       out_row_idx, out_row);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("beat_row",  64'(out_row),     64'(e.row));
                chk("beat_idx",  64'(out_row_idx), 64'(e.idx));
                chk("beat_last", 64'(out_last),    64'(e.last));
            end
        end
        stall_prev = out_valid && !out_ready;
        held_row   = out_row;
        held_idx   = out_row_idx;
        held_last  = out_last;
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic ready_pat [7];
        ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        reset          = 1'b0;
        calc_done_flag = 1'b0;
        out_ready      = 1'b0;
        in_c           = '0;
        #12;
        chk("rst_valid",   64'(out_valid),   64'd0);
        chk("rst_busy",    64'(busy),        64'd0);
        chk("rst_overrun", 64'(overrun),     64'd0);
        chk("rst_idx",     64'(out_row_idx), 64'd0);
        chk("rst_last",    64'(out_last),    64'd0);
        chk("rst_row",     64'(out_row),     64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        cyc();

        // Basic drain with flag held high afterwards
        out_ready      = 1'b1;
        in_c           = mk_in(16'h0000);
        calc_done_flag = 1'b1;
        push_rows(16'h0000);
        cyc();
        chk("lat_valid", 64'(out_valid), 64'd1);
        chk("lat_busy",  64'(busy),      64'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("basic_cont_valid", 64'(out_valid), 64'd1);
        end
        cyc();
        chk("basic_end_valid", 64'(out_valid), 64'd0);
        chk("basic_end_busy",  64'(busy),      64'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("basic_no_redrain", 64'(out_valid), 64'd0);
        end
        chk("basic_sb_empty", 64'(sb.size()), 64'd0);
        chk("basic_overrun",  64'(overrun),   64'd0);

        // Backpressure
        calc_done_flag = 1'b0;
        cyc();
        calc_done_flag = 1'b1;
        out_ready      = 1'b0;
        push_rows(16'h0000);
        cyc();
        for (int i = 0; i < 7; i++) begin
            out_ready = ready_pat[i];
            cyc();
        end
        chk("bp_end_valid", 64'(out_valid), 64'd0);
        chk("bp_sb_empty",  64'(sb.size()), 64'd0);

        // Overrun: new result arrives during the row-1 stall
        calc_done_flag = 1'b0;
        cyc();
        calc_done_flag = 1'b1;
        out_ready      = 1'b0;
        push_rows(16'h0000);
        cyc();
        out_ready = 1'b1;
        cyc();
        out_ready      = 1'b0;
        calc_done_flag = 1'b0;
        cyc();
        in_c           = {H*W{16'hFFFF}};
        calc_done_flag = 1'b1;
        cyc();
        chk("ovr_set",   64'(overrun),     64'd1);
        chk("ovr_idx",   64'(out_row_idx), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        chk("ovr_sticky",    64'(overrun),   64'd1);
        chk("ovr_end_valid", 64'(out_valid), 64'd0);
        chk("ovr_sb_empty",  64'(sb.size()), 64'd0);

        // Async reset mid-drain
        calc_done_flag = 1'b0;
        cyc();
        in_c           = mk_in(16'h0000);
        calc_done_flag = 1'b1;
        push_rows(16'h0000);
        cyc();
        cyc();
        cyc();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid",   64'(out_valid),   64'd0);
        chk("arst_busy",    64'(busy),        64'd0);
        chk("arst_overrun", 64'(overrun),     64'd0);
        chk("arst_idx",     64'(out_row_idx), 64'd0);
        chk("arst_last",    64'(out_last),    64'd0);
        sb.delete();
        stall_prev     = 1'b0;
        calc_done_flag = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("arst_quiet", 64'(out_valid), 64'd0);
        end

        // Back-to-back: rise coincides with acceptance of row 3
        out_ready      = 1'b1;
        in_c           = mk_in(16'h0000);
        calc_done_flag = 1'b1;
        push_rows(16'h0000);
        cyc();
        calc_done_flag = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("b2b_at_last", 64'(out_row_idx), 64'd3);
        in_c           = mk_in(16'h1000);
        calc_done_flag = 1'b1;
        push_rows(16'h1000);
        cyc();
        chk("b2b_valid",   64'(out_valid),   64'd1);
        chk("b2b_idx",     64'(out_row_idx), 64'd0);
        chk("b2b_row",     64'(out_row),     64'(mk_row(16'h1000, 0)));
        chk("b2b_overrun", 64'(overrun),     64'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("b2b_cont_valid", 64'(out_valid), 64'd1);
        end
        cyc();
        chk("b2b_end_valid",   64'(out_valid), 64'd0);
        chk("b2b_end_overrun", 64'(overrun),   64'd0);
        chk("b2b_sb_empty",    64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
